// File: rtl/emu_time_pkg.sv
// Shared types for the emulation-time scheduler: host command encodings and scheduler states.
package emu_time_pkg;

  typedef enum logic [1:0] {
    CMD_PAUSE     = 2'd0,
    CMD_RUN       = 2'd1,
    CMD_RUN_UNTIL = 2'd2,
    CMD_STEP      = 2'd3
  } ctrl_mode_t;

  typedef enum logic [2:0] {
    ST_PAUSED  = 3'd0,
    ST_RUNNING = 3'd1,
    ST_UNTIL   = 3'd2,
    ST_STEP    = 3'd3,
    ST_DONE    = 3'd4
  } tm_state_t;

  function automatic logic is_halted(input tm_state_t s);
    return (s == ST_PAUSED) || (s == ST_DONE);
  endfunction

endpackage

// File: rtl/emu_dt_min_tree.sv
// Masked minimum over all dt requests, built as a balanced binary tree with DT_MAX as identity.
module emu_dt_min_tree #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned DT_WIDTH = 27,
  parameter logic [DT_WIDTH-1:0] DT_MAX = {DT_WIDTH{1'b1}}
) (
  input  logic [N_REQ-1:0][DT_WIDTH-1:0] dt_req,
  input  logic [N_REQ-1:0]               req_en,
  output logic [DT_WIDTH-1:0]            dt_min
);

  localparam int unsigned LG = (N_REQ > 1) ? $clog2(N_REQ) : 0;
  localparam int unsigned P  = 1 << LG;

  // Level 0 holds masked, clamped leaves; padding leaves sit at the identity value.
  for (genvar l = 0; l <= LG; l++) begin : g_lvl
    logic [DT_WIDTH-1:0] v [P >> l];
    if (l == 0) begin : g_leaf
      for (genvar i = 0; i < P; i++) begin : g_i
        if (i < N_REQ) begin : g_real
          assign v[i] = (req_en[i] && (dt_req[i] < DT_MAX)) ? dt_req[i] : DT_MAX;
        end else begin : g_pad
          assign v[i] = DT_MAX;
        end
      end
    end else begin : g_node
      for (genvar i = 0; i < (P >> l); i++) begin : g_i
        assign v[i] = (g_lvl[l-1].v[2*i] < g_lvl[l-1].v[2*i+1]) ?
                      g_lvl[l-1].v[2*i] : g_lvl[l-1].v[2*i+1];
      end
    end
  end

  assign dt_min = g_lvl[LG].v[0];

endmodule

// File: rtl/emu_time_manager.sv
// Global emulation-time scheduler: picks the per-cycle emu_dt from the requesters and host state,
// and owns emu_time, the run-until stop time and the host run/pause/step controls.
module emu_time_manager
  import emu_time_pkg::*;
#(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned DT_WIDTH   = 27,
  parameter int unsigned TIME_WIDTH = 64,
  parameter logic [DT_WIDTH-1:0] DT_MAX = {DT_WIDTH{1'b1}}
) (
  input  logic                           emu_clk,
  input  logic                           emu_rst_n,
  input  logic [N_REQ-1:0][DT_WIDTH-1:0] dt_req,
  input  logic [N_REQ-1:0]               req_en,
  input  logic                           ctrl_valid,
  input  logic [1:0]                     ctrl_mode,
  input  logic [TIME_WIDTH-1:0]          ctrl_data,
  output logic                           ctrl_ready,
  output logic [DT_WIDTH-1:0]            emu_dt,
  output logic [TIME_WIDTH-1:0]          emu_time,
  output logic                           halted
);

  tm_state_t             state_q, state_d;
  logic [TIME_WIDTH-1:0] time_q, stop_q, stop_d, rem;
  logic [DT_WIDTH-1:0]   dt_min, dt_sel;
  logic                  ready_q, halted_q, accept;

  emu_dt_min_tree #(
    .N_REQ    (N_REQ),
    .DT_WIDTH (DT_WIDTH),
    .DT_MAX   (DT_MAX)
  ) u_min_tree (
    .dt_req (dt_req),
    .req_en (req_en),
    .dt_min (dt_min)
  );

  // Zero-latency step selection; consumers compare against it in the same cycle.
  always_comb begin
    dt_sel = '0;
    rem    = stop_q - time_q;
    case (state_q)
      ST_RUNNING, ST_STEP: dt_sel = dt_min;
      ST_UNTIL: begin
        if (|rem[TIME_WIDTH-1:DT_WIDTH]) dt_sel = dt_min;
        else dt_sel = (rem[DT_WIDTH-1:0] < dt_min) ? rem[DT_WIDTH-1:0] : dt_min;
      end
      default: dt_sel = '0;
    endcase
  end

  assign emu_dt = emu_rst_n ? dt_sel : '0;
  assign accept = ctrl_valid & ready_q;

  // Automatic transitions first, so an accepted host command overrides them.
  always_comb begin
    state_d = state_q;
    stop_d  = stop_q;
    if ((state_q == ST_UNTIL) && ((time_q + TIME_WIDTH'(dt_sel)) == stop_q)) state_d = ST_DONE;
    if ((state_q == ST_STEP) && (dt_sel != '0)) state_d = ST_DONE;
    if (accept) begin
      case (ctrl_mode_t'(ctrl_mode))
        CMD_PAUSE: state_d = ST_PAUSED;
        CMD_RUN:   state_d = ST_RUNNING;
        CMD_RUN_UNTIL: begin
          stop_d  = ctrl_data;
          state_d = (ctrl_data <= time_q) ? ST_DONE : ST_UNTIL;
        end
        CMD_STEP:  state_d = ST_STEP;
        default:   state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge emu_clk) begin
    if (!emu_rst_n) begin
      state_q  <= ST_PAUSED;
      time_q   <= '0;
      stop_q   <= '0;
      ready_q  <= 1'b0;
      halted_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      time_q   <= time_q + TIME_WIDTH'(dt_sel);
      stop_q   <= stop_d;
      ready_q  <= 1'b1;
      halted_q <= is_halted(state_d);
    end
  end

  assign ctrl_ready = ready_q;
  assign emu_time   = time_q;
  assign halted     = halted_q;

endmodule

// File: tb/tb_emu_time_manager.sv
// Directed bench for emu_time_manager: spec-level model checked every cycle plus literal checkpoints.
module tb_emu_time_manager;
  import emu_time_pkg::*;

  localparam logic [63:0] DT_MAX64 = 64'd134217727;
  localparam int S_PAUSED = 0, S_RUN = 1, S_UNTIL = 2, S_STEP = 3, S_DONE = 4;

  logic             emu_clk = 1'b0;
  logic             emu_rst_n;
  logic [3:0][26:0] dt_req;
  logic [3:0]       req_en;
  logic             ctrl_valid;
  logic [1:0]       ctrl_mode;
  logic [63:0]      ctrl_data;
  logic             ctrl_ready;
  logic [26:0]      emu_dt;
  logic [63:0]      emu_time;
  logic             halted;

  // Narrow-time instance: a 64-bit wrap is out of reach in simulation, 32 bits is not.
  logic             w_rst_n;
  logic [3:0][26:0] w_dt_req;
  logic [3:0]       w_req_en;
  logic             w_valid;
  logic [1:0]       w_mode;
  logic [31:0]      w_data;
  logic             w_ready;
  logic [26:0]      w_dt;
  logic [31:0]      w_time;
  logic             w_halted;

  int total = 0;
  int bad   = 0;

  int          m_st;
  logic [63:0] m_time, m_stop;
  logic        m_ready, m_halt;
  logic        m_valid = 1'b0;

  always #5 emu_clk = ~emu_clk;

  emu_time_manager #(.N_REQ(4), .DT_WIDTH(27), .TIME_WIDTH(64)) dut (
    .emu_clk(emu_clk), .emu_rst_n(emu_rst_n), .dt_req(dt_req), .req_en(req_en),
    .ctrl_valid(ctrl_valid), .ctrl_mode(ctrl_mode), .ctrl_data(ctrl_data),
    .ctrl_ready(ctrl_ready), .emu_dt(emu_dt), .emu_time(emu_time), .halted(halted)
  );

  emu_time_manager #(.N_REQ(4), .DT_WIDTH(27), .TIME_WIDTH(32)) dut_w (
    .emu_clk(emu_clk), .emu_rst_n(w_rst_n), .dt_req(w_dt_req), .req_en(w_req_en),
    .ctrl_valid(w_valid), .ctrl_mode(w_mode), .ctrl_data(w_data),
    .ctrl_ready(w_ready), .emu_dt(w_dt), .emu_time(w_time), .halted(w_halted)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected step from the rules: smallest enabled request, capped, then limited by the mode.
  function automatic logic [63:0] f_dt();
    logic [63:0] best = DT_MAX64;
    logic [63:0] rem;
    for (int i = 0; i < 4; i++)
      if (req_en[i] && (64'(dt_req[i]) < best)) best = 64'(dt_req[i]);
    if (!emu_rst_n) return 64'd0;
    case (m_st)
      S_RUN, S_STEP: return best;
      S_UNTIL: begin
        rem = m_stop - m_time;
        return (rem < best) ? rem : best;
      end
      default: return 64'd0;
    endcase
  endfunction

  always @(posedge emu_clk) begin : p_model
    logic [63:0] d;
    int ns;
    d = f_dt();
    if (!emu_rst_n) begin
      m_st = S_PAUSED; m_time = 0; m_stop = 0; m_ready = 1'b0; m_halt = 1'b1; m_valid = 1'b1;
    end else begin
      ns = m_st;
      if (m_st == S_UNTIL && (m_time + d) == m_stop) ns = S_DONE;
      if (m_st == S_STEP && d != 0) ns = S_DONE;
      if (ctrl_valid && m_ready) begin
        case (ctrl_mode)
          2'd0: ns = S_PAUSED;
          2'd1: ns = S_RUN;
          2'd2: begin m_stop = ctrl_data; ns = (ctrl_data <= m_time) ? S_DONE : S_UNTIL; end
          default: ns = S_STEP;
        endcase
      end
      m_time  = m_time + d;
      m_st    = ns;
      m_ready = 1'b1;
      m_halt  = (ns == S_PAUSED) || (ns == S_DONE);
    end
  end

  always @(negedge emu_clk) begin
    if (m_valid) begin
      chk("emu_dt", 64'(emu_dt), f_dt());
      chk("emu_time", emu_time, m_time);
      chk("halted", 64'(halted), 64'(m_halt));
      chk("ctrl_ready", 64'(ctrl_ready), 64'(m_ready));
    end
  end

  task automatic step();
    @(posedge emu_clk); #1;
  endtask

  task automatic mid();
    @(negedge emu_clk);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    emu_rst_n = 0; dt_req = '0; req_en = '0; ctrl_valid = 0; ctrl_mode = CMD_PAUSE; ctrl_data = '0;
    w_rst_n = 0; w_dt_req = '0; w_req_en = '0; w_valid = 0; w_mode = CMD_PAUSE; w_data = '0;
    repeat (2) step();
    mid();
    chk("rst_dt", 64'(emu_dt), 64'd0);
    chk("rst_halted", 64'(halted), 64'd1);
    chk("rst_ready", 64'(ctrl_ready), 64'd0);
    chk("rst_time", emu_time, 64'd0);
    step(); emu_rst_n = 1;
    step(); mid();
    chk("ready_up", 64'(ctrl_ready), 64'd1);

    // RUN with requests {60,90,25,40}: min 25 each cycle.
    step(); dt_req[0] = 27'd60; dt_req[1] = 27'd90; dt_req[2] = 27'd25; dt_req[3] = 27'd40;
    req_en = 4'hF; ctrl_valid = 1; ctrl_mode = CMD_RUN;
    step(); ctrl_valid = 0; mid();
    chk("run_dt", 64'(emu_dt), 64'd25);
    chk("run_t0", emu_time, 64'd0);
    step(); mid(); chk("run_t25", emu_time, 64'd25);
    step(); mid(); chk("run_t50", emu_time, 64'd50);
    step(); mid(); chk("run_t75", emu_time, 64'd75);

    // RUN_UNTIL 130 from 100: 25 (old state), then clamped 5, then DONE.
    step(); ctrl_valid = 1; ctrl_mode = CMD_RUN_UNTIL; ctrl_data = 64'd130; mid();
    chk("until_acc_dt", 64'(emu_dt), 64'd25);
    chk("until_acc_t", emu_time, 64'd100);
    step(); ctrl_valid = 0; mid();
    chk("until_clamp_dt", 64'(emu_dt), 64'd5);
    chk("until_t125", emu_time, 64'd125);
    step(); mid();
    chk("done_t", emu_time, 64'd130);
    chk("done_halted", 64'(halted), 64'd1);
    chk("done_dt", 64'(emu_dt), 64'd0);
    step(); mid(); chk("done_hold_t", emu_time, 64'd130);

    // All requesters masked gives DT_MAX; enabling one takes effect the same cycle.
    step(); req_en = 4'b0000; ctrl_valid = 1; ctrl_mode = CMD_RUN;
    step(); ctrl_valid = 0; mid();
    chk("nomask_dt", 64'(emu_dt), DT_MAX64);
    step(); req_en = 4'b0100; dt_req[2] = 27'd7; mid();
    chk("one_en_dt", 64'(emu_dt), 64'd7);
    chk("one_en_t", emu_time, 64'd134217857);

    // STEP stalls on a zero request, then issues one 12 and finishes.
    step(); req_en = 4'b0001; dt_req[0] = 27'd0; ctrl_valid = 1; ctrl_mode = CMD_STEP;
    step(); ctrl_valid = 0; mid();
    chk("step_wait_dt", 64'(emu_dt), 64'd0);
    chk("step_wait_halted", 64'(halted), 64'd0);
    step(); mid(); chk("step_wait2_dt", 64'(emu_dt), 64'd0);
    step(); mid(); chk("step_wait3_dt", 64'(emu_dt), 64'd0);
    step(); dt_req[0] = 27'd12; mid();
    chk("step_go_dt", 64'(emu_dt), 64'd12);
    chk("step_go_t", emu_time, 64'd134217864);
    step(); mid();
    chk("step_done_halted", 64'(halted), 64'd1);
    chk("step_done_t", emu_time, 64'd134217876);

    // A RUN command preempts a STEP that is still waiting.
    step(); dt_req[0] = 27'd0; ctrl_valid = 1; ctrl_mode = CMD_STEP;
    step(); ctrl_valid = 0;
    step(); ctrl_valid = 1; ctrl_mode = CMD_RUN;
    step(); ctrl_valid = 0; dt_req[0] = 27'd3; mid();
    chk("preempt_dt", 64'(emu_dt), 64'd3);
    step(); mid();
    chk("preempt_run_halted", 64'(halted), 64'd0);

    // RUN_UNTIL to exactly the current time goes straight to DONE.
    step(); ctrl_valid = 1; ctrl_mode = CMD_RUN_UNTIL; ctrl_data = m_time;
    step(); ctrl_valid = 0; mid();
    chk("until_eq_halted", 64'(halted), 64'd1);

    // Reset in the middle of an UNTIL run.
    step(); dt_req[0] = 27'd10; ctrl_valid = 1; ctrl_mode = CMD_RUN_UNTIL; ctrl_data = m_time + 64'd1000;
    step(); ctrl_valid = 0;
    step(); step(); emu_rst_n = 0; mid();
    chk("rst_mid_dt", 64'(emu_dt), 64'd0);
    step(); emu_rst_n = 1; mid();
    chk("rst_mid_t", emu_time, 64'd0);
    chk("rst_mid_dt2", 64'(emu_dt), 64'd0);
    chk("rst_mid_halted", 64'(halted), 64'd1);

    // PAUSE in the same cycle as the automatic DONE.
    step(); ctrl_valid = 1; ctrl_mode = CMD_RUN_UNTIL; ctrl_data = 64'd30;
    step(); ctrl_valid = 0;
    step();
    step(); ctrl_valid = 1; ctrl_mode = CMD_PAUSE; mid();
    chk("race_pause_dt", 64'(emu_dt), 64'd10);
    chk("race_pause_t20", emu_time, 64'd20);
    step(); ctrl_valid = 0; mid();
    chk("race_pause_t", emu_time, 64'd30);
    chk("race_pause_halted", 64'(halted), 64'd1);

    // RUN in the same cycle as the automatic DONE: running continues.
    step(); ctrl_valid = 1; ctrl_mode = CMD_RUN_UNTIL; ctrl_data = 64'd60;
    step(); ctrl_valid = 0;
    step();
    step(); ctrl_valid = 1; ctrl_mode = CMD_RUN; mid();
    chk("race_run_t50", emu_time, 64'd50);
    step(); ctrl_valid = 0; mid();
    chk("race_run_t", emu_time, 64'd60);
    chk("race_run_dt", 64'(emu_dt), 64'd10);
    chk("race_run_halted", 64'(halted), 64'd0);

    // RUN_UNTIL in the past goes to DONE.
    step(); ctrl_valid = 1; ctrl_mode = CMD_RUN_UNTIL; ctrl_data = 64'd5;
    step(); ctrl_valid = 0; mid();
    chk("past_halted", 64'(halted), 64'd1);
    chk("past_dt", 64'(emu_dt), 64'd0);
    chk("past_t", emu_time, 64'd80);

    // Wrap on the narrow instance: 32 x DT_MAX + 22 = 2^32-10, then +25 wraps to 15.
    step(); w_rst_n = 1;
    step(); w_req_en = 4'b0000; w_valid = 1; w_mode = CMD_RUN;
    step(); w_valid = 0; mid();
    chk("w_dt_max", 64'(w_dt), DT_MAX64);
    repeat (32) step();
    w_req_en = 4'b0001; w_dt_req[0] = 27'd22; mid();
    chk("w_t_pre", 64'(w_time), 64'hFFFF_FFE0);
    step(); w_dt_req[0] = 27'd25; mid();
    chk("w_t_near", 64'(w_time), 64'hFFFF_FFF6);
    chk("w_dt25", 64'(w_dt), 64'd25);
    step(); w_valid = 1; w_mode = CMD_RUN_UNTIL; w_data = 32'd5; mid();
    chk("w_t_wrap", 64'(w_time), 64'd15);
    step(); w_valid = 0; mid();
    chk("w_past_halted", 64'(w_halted), 64'd1);
    chk("w_past_dt", 64'(w_dt), 64'd0);
    chk("w_past_t", 64'(w_time), 64'd40);

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
